nn_layer_engine: RTL and testbench

- Parametrised fully-connected layer: NUM_NEURONS MAC lanes generated from one parameter; no per-neuron hand instantiation.
- Each lane has its own weight RAM (NUM_WEIGHT words) and bias register, loaded over the shared config bus.
- A broadcast input stream is accumulated per lane; bias and activation are applied, then all lane results are emitted together.
- Sits between layer-(n-1) output serialiser and layer-(n+1) input in the MNIST datapath; adds input backpressure and a selectable activation.

---
 rtl/nn_layer_engine_if.sv | 32 +++
 rtl/nn_layer_engine.sv | 177 +++++++++++++++++
 tb/tb_nn_layer_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_engine_if.sv
// Config bus and sample/result stream shared between the layer engine and
// its neighbours. The master modport is the driver side (serialiser,
// config loader, or a testbench). The slave modport is the engine.
interface nn_layer_engine_if #(
   parameter int NUM_NEURONS = 30,
   parameter int DATA_WIDTH  = 16
);
   logic                                weightValid;
   logic                                biasValid;
   logic [15:0]                         weightValue;
   logic [15:0]                         biasValue;
   logic [15:0]                         config_layer_num;
   logic [15:0]                         config_neuron_num;
   logic                                x_valid;
   logic                                x_ready;
   logic signed [DATA_WIDTH-1:0]        x_in;
   logic [NUM_NEURONS-1:0]              o_valid;
   logic [NUM_NEURONS*DATA_WIDTH-1:0]   x_out;
   logic                                busy;

   modport master (
      output weightValid, biasValid, weightValue, biasValue,
             config_layer_num, config_neuron_num, x_valid, x_in,
      input  x_ready, o_valid, x_out, busy
   );

   modport slave (
      input  weightValid, biasValid, weightValue, biasValue,
             config_layer_num, config_neuron_num, x_valid, x_in,
      output x_ready, o_valid, x_out, busy
   );
endinterface

// File: rtl/nn_layer_engine.sv
// Fully-connected layer engine: NUM_NEURONS MAC lanes share one broadcast
// input stream. Each lane owns a weight RAM and a bias register that are
// loaded over the config bus. Results from all lanes are emitted together,
// 3 cycles after the last sample.
// Optional build macro NN_LAYER_SAT_EN: saturate outputs instead of
// truncating them, and add the sticky per-lane sat_flag port.
module nn_layer_engine #(
   parameter int    NUM_NEURONS = 30,
   parameter int    NUM_WEIGHT  = 784,
   parameter int    DATA_WIDTH  = 16,
   parameter int    INT_WIDTH   = 4,
   parameter int    LAYER_NUM   = 1,
   parameter string ACT_TYPE    = "relu"
) (
   input  logic                    clk,
   input  logic                    rst,
   nn_layer_engine_if.slave        bus
`ifdef NN_LAYER_SAT_EN
   ,
   output logic [NUM_NEURONS-1:0]  sat_flag
`endif
);
   localparam int FRAC  = DATA_WIDTH - INT_WIDTH;
   localparam int ACC_W = 2*DATA_WIDTH + $clog2(NUM_WEIGHT);
   localparam int SUM_W = ACC_W + 1;
   localparam int CNT_W = $clog2(NUM_WEIGHT + 1);
   localparam int IDX_W = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
   localparam bit RELU  = (ACT_TYPE == "relu");
`ifdef NN_LAYER_SAT_EN
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2**(DATA_WIDTH-1) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2**(DATA_WIDTH-1)));
`endif

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_in_cnt;
   logic               r_drain_cnt;
   logic               r_busy;
   logic               r_out_vld;
   logic               r_prod_vld;
   logic               w_xfer, w_last, w_out, w_cfg_ok;
   logic [IDX_W-1:0]   w_idx;

   assign bus.x_ready = ((r_state == S_IDLE) || (r_state == S_ACCUM)) &&
                        (r_in_cnt < CNT_W'(NUM_WEIGHT));
   assign w_xfer   = bus.x_valid & bus.x_ready;
   assign w_last   = (r_in_cnt == CNT_W'(NUM_WEIGHT - 1));
   assign w_out    = (r_state == S_OUT);
   assign w_idx    = r_in_cnt[IDX_W-1:0];
   // Lane selection below is an exact match on config_neuron_num, so
   // out-of-range lane numbers select nothing.
   assign w_cfg_ok = !r_busy && (bus.config_layer_num == 16'(LAYER_NUM));
   assign bus.o_valid = {NUM_NEURONS{r_out_vld}};
   assign bus.busy    = r_busy;

   // Next-state logic: collect NUM_WEIGHT samples, drain 2 cycles, emit.
   always_comb begin
      // NOTE: assign a default before the case so every path writes the
      // signal; otherwise synthesis infers a latch.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_xfer) w_state_nxt = w_last ? S_DRAIN : S_ACCUM;
         S_ACCUM: if (w_xfer && w_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (r_drain_cnt) w_state_nxt = S_OUT;
         S_OUT:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register and shared control: input count, drain timer, busy, strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_in_cnt    <= '0;
         r_drain_cnt <= 1'b0;
         r_busy      <= 1'b0;
         r_out_vld   <= 1'b0;
         r_prod_vld  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register here sample
         // the pre-edge values, so statement order does not matter.
         r_state     <= w_state_nxt;
         r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
         r_prod_vld  <= w_xfer;
         r_out_vld   <= w_out;
         if (w_xfer)     r_in_cnt <= r_in_cnt + 1'b1;
         else if (w_out) r_in_cnt <= '0;
         if (w_xfer)     r_busy <= 1'b1;
         else if (w_out) r_busy <= 1'b0;
      end
   end

   for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lane
      logic signed [DATA_WIDTH-1:0]   r_wram [NUM_WEIGHT];
      logic [IDX_W-1:0]               r_wptr;
      logic signed [DATA_WIDTH-1:0]   r_bias;
      logic signed [DATA_WIDTH-1:0]   r_y;
      logic signed [2*DATA_WIDTH-1:0] r_prod;
      logic signed [ACC_W-1:0]        r_acc;
      logic signed [2*DATA_WIDTH-1:0] w_x_ext, w_w_ext;
      logic signed [SUM_W-1:0]        w_sum, w_y, w_act;
      logic signed [DATA_WIDTH-1:0]   w_y_out;
      logic                           w_sel;

      assign w_sel   = w_cfg_ok && (bus.config_neuron_num == 16'(g));
      assign w_x_ext = (2*DATA_WIDTH)'(bus.x_in);
      assign w_w_ext = (2*DATA_WIDTH)'(r_wram[w_idx]);

      // Weight RAM write port at the lane's write pointer.
      // NOTE: no reset on the RAM; it maps onto RAM primitives, and every
      // word is written before it is used.
      always_ff @(posedge clk) begin
         if (w_sel && bus.weightValid)
            r_wram[r_wptr] <= bus.weightValue[DATA_WIDTH-1:0];
      end

      // Write pointer (wraps at NUM_WEIGHT) and bias register.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_wptr <= '0;
            r_bias <= '0;
         end else if (w_sel) begin
            if (bus.weightValid)
               r_wptr <= (r_wptr == IDX_W'(NUM_WEIGHT - 1)) ? '0 : r_wptr + 1'b1;
            if (bus.biasValid)
               r_bias <= bus.biasValue[DATA_WIDTH-1:0];
         end
      end

      // Stage 1 multiplies. Stage 2 accumulates and clears when the result is taken.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_prod <= '0;
            r_acc  <= '0;
         end else begin
            if (w_xfer)          r_prod <= w_x_ext * w_w_ext;
            if (w_out)           r_acc  <= '0;
            else if (r_prod_vld) r_acc  <= r_acc + ACC_W'(r_prod);
         end
      end

      // Stage 3: add the aligned bias, rescale, then apply the activation.
      always_comb begin
         w_sum = SUM_W'(r_acc) + (SUM_W'(r_bias) <<< FRAC);
         w_y   = w_sum >>> FRAC;
         w_act = (RELU && (w_y < 0)) ? '0 : w_y;
`ifdef NN_LAYER_SAT_EN
         if (w_act > SAT_MAX)      w_y_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         else if (w_act < SAT_MIN) w_y_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         else                      w_y_out = w_act[DATA_WIDTH-1:0];
`else
         w_y_out = w_act[DATA_WIDTH-1:0];
`endif
      end

      // Result register; it holds until the next OUT cycle.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)       r_y <= '0;
         else if (w_out) r_y <= w_y_out;
      end

      assign bus.x_out[g*DATA_WIDTH +: DATA_WIDTH] = r_y;

`ifdef NN_LAYER_SAT_EN
      logic r_sat;

      // Sticky clip flag; only reset clears it.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)                                         r_sat <= 1'b0;
         else if (w_out && ((w_act > SAT_MAX) || (w_act < SAT_MIN))) r_sat <= 1'b1;
      end

      assign sat_flag[g] = r_sat;
`endif
   end
endmodule

// File: tb/tb_nn_layer_engine.sv
// Self-checking bench for nn_layer_engine. It uses 3 lanes, 4 weights and
// Q4.12 data. Two engines (relu and none) receive identical stimulus.
// Table-driven inferences on lane 2 are followed by hand-written sequences.
// These cover config routing, pointer wrap, mid-inference reset and
// saturation (NN_LAYER_SAT_EN).
module tb_nn_layer_engine;
   localparam int NN = 3;
   localparam int NW = 4;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   nn_layer_engine_if #(.NUM_NEURONS(NN), .DATA_WIDTH(DW)) if_r ();
   nn_layer_engine_if #(.NUM_NEURONS(NN), .DATA_WIDTH(DW)) if_n ();
`ifdef NN_LAYER_SAT_EN
   logic [NN-1:0] sat_r, sat_n;
`endif

   nn_layer_engine #(.NUM_NEURONS(NN), .NUM_WEIGHT(NW), .DATA_WIDTH(DW),
      .INT_WIDTH(4), .LAYER_NUM(1), .ACT_TYPE("relu")) u_relu (
      .clk(clk), .rst(rst), .bus(if_r)
`ifdef NN_LAYER_SAT_EN
      , .sat_flag(sat_r)
`endif
   );

   nn_layer_engine #(.NUM_NEURONS(NN), .NUM_WEIGHT(NW), .DATA_WIDTH(DW),
      .INT_WIDTH(4), .LAYER_NUM(1), .ACT_TYPE("none")) u_none (
      .clk(clk), .rst(rst), .bus(if_n)
`ifdef NN_LAYER_SAT_EN
      , .sat_flag(sat_n)
`endif
   );

   typedef struct {
      logic [15:0] w;
      logic [15:0] x;
      logic [15:0] b;
      bit          gaps;
      logic [15:0] exp_relu;
      logic [15:0] exp_none;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lane(input logic [NN*DW-1:0] v, input int i);
      return v[i*DW +: DW];
   endfunction

   task automatic set_cfg(input bit wv, input bit bv, input logic [15:0] val,
                          input logic [15:0] layer, input logic [15:0] neuron);
      if_r.weightValid = wv;  if_n.weightValid = wv;
      if_r.biasValid   = bv;  if_n.biasValid   = bv;
      if_r.weightValue = val; if_n.weightValue = val;
      if_r.biasValue   = val; if_n.biasValue   = val;
      if_r.config_layer_num  = layer;  if_n.config_layer_num  = layer;
      if_r.config_neuron_num = neuron; if_n.config_neuron_num = neuron;
   endtask

   task automatic set_x(input bit v, input logic [15:0] x);
      if_r.x_valid = v; if_n.x_valid = v;
      if_r.x_in    = x; if_n.x_in    = x;
   endtask

   task automatic wr_weight(input logic [15:0] layer, input logic [15:0] neuron, input logic [15:0] val);
      @(negedge clk); set_cfg(1'b1, 1'b0, val, layer, neuron);
      @(negedge clk); set_cfg(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic wr_bias(input logic [15:0] layer, input logic [15:0] neuron, input logic [15:0] val);
      @(negedge clk); set_cfg(1'b0, 1'b1, val, layer, neuron);
      @(negedge clk); set_cfg(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic load_lane(input logic [15:0] neuron, input logic [15:0] w, input logic [15:0] b);
      for (int i = 0; i < NW; i++) wr_weight(16'd1, neuron, w);
      wr_bias(16'd1, neuron, b);
   endtask

   // Sends NW samples of value x. With gaps, x_valid drops every other cycle,
   // x_valid stays high into DRAIN, and a bias write is attempted while busy.
   // lat is the count of cycles from the last transfer to o_valid (-1 if none).
   task automatic run_inference(input logic [15:0] x, input bit gaps,
                                output int lat, output bit ready_bad);
      int sent = 0;
      int cyc  = 0;
      bit v;
      while (sent < NW && cyc < 64) begin
         @(negedge clk);
         v = !(gaps && cyc[0]);
         set_x(v, x);
         if (gaps && sent == 2) set_cfg(1'b0, 1'b1, 16'h7000, 16'd1, 16'd2);
         else                   set_cfg(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
         if (v && if_r.x_ready) sent++;
         cyc++;
      end
      lat = -1;
      ready_bad = 1'b0;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
         @(negedge clk);
         set_cfg(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
         if (!gaps || k >= 3) set_x(1'b0, x);
         if (if_r.o_valid !== '0) lat = k - 1;
         else if (if_r.x_ready)   ready_bad = 1'b1;
      end
   endtask

   initial begin
      int  lat;
      bit  rbad;
      bit  seen;

      // Q4.12 vectors for lane 2: 4 x (x*w) + b, then the activation.
      vecs[0] = '{16'h1000, 16'h1000, 16'h0800, 1'b0, 16'h4800, 16'h4800};
      vecs[1] = '{16'hF000, 16'h1000, 16'h0000, 1'b0, 16'h0000, 16'hC000};
      vecs[2] = '{16'h1000, 16'h1000, 16'h0800, 1'b1, 16'h4800, 16'h4800};
      vecs[3] = '{16'h0800, 16'h2000, 16'hF000, 1'b0, 16'h3000, 16'h3000};
`ifdef NN_LAYER_SAT_EN
      vecs[4] = '{16'h1800, 16'hE000, 16'h0400, 1'b0, 16'h0000, 16'h8000};
`else
      vecs[4] = '{16'h1800, 16'hE000, 16'h0400, 1'b0, 16'h0000, 16'h4400};
`endif
      vecs[5] = '{16'h7FFF, 16'h0000, 16'h0100, 1'b1, 16'h0100, 16'h0100};
`ifdef NN_LAYER_SAT_EN
      vecs[6] = '{16'h7000, 16'h7000, 16'h0000, 1'b0, 16'h7FFF, 16'h7FFF};
`else
      vecs[6] = '{16'h7000, 16'h7000, 16'h0000, 1'b0, 16'h4000, 16'h4000};
`endif

      set_cfg(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      set_x(1'b0, 16'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Reset state
      check("reset x_out",   if_r.x_out,   '0);
      check("reset o_valid", if_r.o_valid, '0);
      check("reset x_ready", if_r.x_ready, 1'b1);
      check("reset busy",    if_r.busy,    1'b0);
`ifdef NN_LAYER_SAT_EN
      check("reset sat_flag", {sat_r, sat_n}, '0);
`endif

      // Config routing: writes aimed at layer 2 must not touch lane 2.
      load_lane(16'd2, 16'h1000, 16'h0800);
      wr_weight(16'd2, 16'd2, 16'hF000);
      wr_bias(16'd2, 16'd2, 16'h7000);
      run_inference(16'h1000, 1'b0, lat, rbad);
      check("routing lane2", lane(if_r.x_out, 2), 16'h4800);
      check("routing latency", lat, 3);

      // Table-driven inferences on lane 2
      foreach (vecs[i]) begin
         load_lane(16'd2, vecs[i].w, vecs[i].b);
         run_inference(vecs[i].x, vecs[i].gaps, lat, rbad);
         check($sformatf("v%0d relu lane2", i), lane(if_r.x_out, 2), vecs[i].exp_relu);
         check($sformatf("v%0d none lane2", i), lane(if_n.x_out, 2), vecs[i].exp_none);
         check($sformatf("v%0d latency", i), lat, 3);
         check($sformatf("v%0d o_valid all", i), if_r.o_valid, 3'b111);
         check($sformatf("v%0d x_ready drain", i), rbad, 1'b0);
         @(negedge clk);
         check($sformatf("v%0d o_valid pulse", i), if_r.o_valid, 3'b000);
         check($sformatf("v%0d x_out hold", i), lane(if_r.x_out, 2), vecs[i].exp_relu);
      end

`ifdef NN_LAYER_SAT_EN
      check("sat_flag relu lane2", sat_r[2], 1'b1);
      check("sat_flag none lane2", sat_n[2], 1'b1);
`endif

      // Weight pointer wrap: the fifth write to lane 0 overwrites w[0].
      wr_weight(16'd1, 16'd0, 16'h1000);
      wr_weight(16'd1, 16'd0, 16'h1000);
      wr_weight(16'd1, 16'd0, 16'h1000);
      wr_weight(16'd1, 16'd0, 16'h1000);
      wr_weight(16'd1, 16'd0, 16'h3000);
      run_inference(16'h1000, 1'b0, lat, rbad);
      check("wrap lane0", lane(if_r.x_out, 0), 16'h6000);
      check("wrap latency", lat, 3);

      // Mid-inference reset after 2 of 4 samples
      load_lane(16'd2, 16'h1000, 16'h0800);
      @(negedge clk); set_x(1'b1, 16'h1000);
      @(negedge clk);
      @(negedge clk); set_x(1'b0, 16'h0); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (if_r.o_valid !== '0) seen = 1'b1;
      end
      check("abort no o_valid", seen, 1'b0);
      check("abort busy",       if_r.busy, 1'b0);
      check("abort x_out",      lane(if_r.x_out, 2), 16'h0000);
`ifdef NN_LAYER_SAT_EN
      check("abort sat_flag", {sat_r[2], sat_n[2]}, 2'b00);
`endif
      // Weights survive reset and the bias is cleared: 4 x 1.0 -> 4.0.
      run_inference(16'h1000, 1'b0, lat, rbad);
      check("post-reset lane2", lane(if_r.x_out, 2), 16'h4000);
      check("post-reset latency", lat, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
